serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_pkg.sv | 10 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 100 ++++++++++
 tb/tb_serial_subtractor.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// 1-bit full subtractor: d = x - y - bin, with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b over WIDTH cycles, LSB first.
// Handshake: start is sampled only in IDLE; busy covers BUSY and DONE; done pulses for one cycle with diff/borrow valid.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sd;
  logic [WIDTH-1:0] sd_next;
  logic             bff;
  logic [CNT_W-1:0] cnt;
  logic             d;
  logic             bout;
  logic             last_bit;

  full_subtractor u_fs (
    .x   (sa[0]),
    .y   (sb[0]),
    .bin (bff),
    .d   (d),
    .bout(bout)
  );

  // Shift form keeps WIDTH=1 legal: the new bit lands in the MSB.
  assign sd_next  = (sd >> 1) | (WIDTH'(d) << (WIDTH - 1));
  assign last_bit = (cnt == LAST_CNT);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      sd     <= '0;
      bff    <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            sd  <= '0;
            bff <= 1'b0;
            cnt <= '0;
          end
        end
        BUSY: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sd  <= sd_next;
          bff <= bout;
          cnt <= cnt + CNT_W'(1);
          // Publish only on the final bit so consumers never see a partial result.
          if (last_bit) begin
            diff   <= sd_next;
            borrow <= bout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH = 8, 1 and 16.
module tb_serial_subtractor;

  typedef struct packed {
    logic [31:0] due;
    logic        borrow;
    logic [15:0] diff;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  start_v = '0;
  logic [15:0] a_bus = '0;
  logic [15:0] b_bus = '0;
  logic [2:0]  busy_v;
  logic [2:0]  done_v;
  logic [2:0]  borrow_v;
  logic [7:0]  diff8;
  logic [0:0]  diff1;
  logic [15:0] diff16;

  int unsigned cyc = 0;
  logic        rst_q = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        exp_q0[$];
  exp_t        exp_q1[$];
  exp_t        exp_q2[$];
  logic [16:0] last_v[3];

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a_bus[7:0]), .b(b_bus[7:0]),
    .busy(busy_v[0]), .done(done_v[0]), .diff(diff8), .borrow(borrow_v[0])
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a_bus[0:0]), .b(b_bus[0:0]),
    .busy(busy_v[1]), .done(done_v[1]), .diff(diff1), .borrow(borrow_v[1])
  );

  serial_subtractor #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a_bus), .b(b_bus),
    .busy(busy_v[2]), .done(done_v[2]), .diff(diff16), .borrow(borrow_v[2])
  );

  // Clock and reset bookkeeping
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  function automatic int width_of(input int i);
    case (i)
      0:       return 8;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  function automatic logic [15:0] diff_of(input int i);
    case (i)
      0:       return {8'h00, diff8};
      1:       return {15'h0000, diff1};
      default: return diff16;
    endcase
  endfunction

  function automatic exp_t model(input int i, input logic [15:0] a, input logic [15:0] b,
                                 input int unsigned due);
    exp_t        e;
    logic [16:0] mask;
    logic [16:0] am;
    logic [16:0] bm;
    mask     = (17'd1 << width_of(i)) - 17'd1;
    am       = {1'b0, a} & mask;
    bm       = {1'b0, b} & mask;
    e.diff   = 16'((am - bm) & mask);
    e.borrow = (am < bm);
    e.due    = due;
    return e;
  endfunction

  function automatic void push_exp(input int i, input exp_t e);
    case (i)
      0:       exp_q0.push_back(e);
      1:       exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endfunction

  function automatic exp_t pop_exp(input int i);
    case (i)
      0:       return exp_q0.pop_front();
      1:       return exp_q1.pop_front();
      default: return exp_q2.pop_front();
    endcase
  endfunction

  function automatic int q_size(input int i);
    case (i)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic void clear_q(input int i);
    case (i)
      0:       exp_q0.delete();
      1:       exp_q1.delete();
      default: exp_q2.delete();
    endcase
  endfunction

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s[w%0d]: observed %0h expected %0h at cycle %0d", tag, width_of(i), obs, exp, cyc);
    end
  endtask

  // Scoreboard: every done pops one expected result; between dones the outputs must hold.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (rst_q) begin
        clear_q(i);
        last_v[i] = '0;
        chk("rst_busy", i, 32'(busy_v[i]), 32'd0);
        chk("rst_done", i, 32'(done_v[i]), 32'd0);
        chk("rst_diff", i, 32'(diff_of(i)), 32'd0);
        chk("rst_borrow", i, 32'(borrow_v[i]), 32'd0);
      end else if (done_v[i]) begin
        chk("done_busy", i, 32'(busy_v[i]), 32'd1);
        chk("done_expected", i, 32'(q_size(i) > 0), 32'd1);
        if (q_size(i) > 0) begin
          e = pop_exp(i);
          chk("diff", i, 32'(diff_of(i)), 32'(e.diff));
          chk("borrow", i, 32'(borrow_v[i]), 32'(e.borrow));
          chk("done_cycle", i, cyc, e.due);
        end
        last_v[i] = {borrow_v[i], diff_of(i)};
      end else begin
        chk("result_hold", i, 32'({borrow_v[i], diff_of(i)}), 32'(last_v[i]));
      end
    end
  end

  // Driver tasks
  task automatic wait_idle(input int sel);
    int n;
    n = 0;
    while (busy_v[sel] !== 1'b0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", sel, 32'(busy_v[sel]), 32'd0);
  endtask

  task automatic run_op(input int sel, input logic [15:0] a, input logic [15:0] b);
    int n;
    wait_idle(sel);
    a_bus        = a;
    b_bus        = b;
    start_v[sel] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[sel] = 1'b0;
    push_exp(sel, model(sel, a, b, cyc + width_of(sel)));
    a_bus = 16'($urandom);
    b_bus = 16'($urandom);
    n = 0;
    while (busy_v[sel] === 1'b1 && n < 64) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", sel, n, width_of(sel) + 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed WIDTH=8 operations
    run_op(0, 16'd200, 16'd55);
    run_op(0, 16'd5, 16'd10);
    run_op(0, 16'd0, 16'd0);
    run_op(0, 16'd255, 16'd255);
    run_op(0, 16'd0, 16'd1);

    // start held high with operands changing every cycle
    wait_idle(0);
    for (int c = 0; c < 30; c++) begin
      a_bus      = 16'($urandom);
      b_bus      = 16'($urandom);
      start_v[0] = 1'b1;
      if (c % 10 == 0) push_exp(0, model(0, a_bus, b_bus, cyc + 1 + 8));
      @(negedge clk);
    end
    start_v[0] = 1'b0;
    wait_idle(0);

    // Reset in the middle of an operation
    a_bus      = 16'd100;
    b_bus      = 16'd30;
    start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    push_exp(0, model(0, 16'd100, 16'd30, cyc + 8));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_op(0, 16'd100, 16'd30);

    // WIDTH=1: all input pairs
    run_op(1, 16'd0, 16'd0);
    run_op(1, 16'd1, 16'd0);
    run_op(1, 16'd0, 16'd1);
    run_op(1, 16'd1, 16'd1);

    // WIDTH=16 boundaries, then random regression on 8 and 16
    run_op(2, 16'hFFFF, 16'h0000);
    run_op(2, 16'h0000, 16'hFFFF);
    for (int k = 0; k < 500; k++) begin
      run_op(0, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)));
      run_op(2, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
    end

    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) chk("queue_drained", i, 32'(q_size(i)), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
